// File: rtl/gray_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_pkg : width-generic binary<->Gray conversion helpers                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gray_pkg;

  localparam int WIDTH_MAX = 32;

  // Callers zero-extend narrower values; zero upper bits leave the result unchanged.
  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
    logic [WIDTH_MAX-1:0] b;
    b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_code_counter_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_decode_stage : one-cycle registered Gray-to-binary decode path      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gray_decode_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_gray,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_bin
);

  logic             r_valid;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] w_bin;

  assign w_bin = WIDTH'(gray2bin(WIDTH_MAX'(i_gray)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_bin   <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_bin <= w_bin;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_bin   = r_bin;

endmodule
`default_nettype wire

// File: rtl/gray_code_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gray_code_counter : up/down binary+Gray counter with load, optional      |
// | saturation, wrap pulse, and an independent Gray decode stage. Rev 1.0    |
// +--------------------------------------------------------------------------+
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap,
  output logic             at_limit,
  input  logic             dec_valid_in,
  input  logic [WIDTH-1:0] gray_in,
  output logic             dec_valid_out,
  output logic [WIDTH-1:0] dec_bin_out
);

  localparam logic [WIDTH-1:0] c_ONES = '1;
  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_at_limit;

  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_at_limit;

  always_comb begin
    w_next = r_bin;
    w_wrap = 1'b0;
    if (load) begin
      w_next = load_val;
    end else if (en) begin
      if (up_dn) begin
        if (r_bin == c_ONES) begin
          if (!SATURATE) begin
            w_next = '0;
            w_wrap = 1'b1;
          end
        end else begin
          w_next = r_bin + c_ONE;
        end
      end else begin
        if (r_bin == '0) begin
          if (!SATURATE) begin
            w_next = c_ONES;
            w_wrap = 1'b1;
          end
        end else begin
          w_next = r_bin - c_ONE;
        end
      end
    end
  end

  // Limit follows the direction requested this cycle, evaluated on the value being loaded/stepped to.
  assign w_at_limit = up_dn ? (w_next == c_ONES) : (w_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_gray     <= '0;
      r_wrap     <= 1'b0;
      r_at_limit <= 1'b0;
    end else begin
      r_bin      <= w_next;
      r_gray     <= WIDTH'(bin2gray(WIDTH_MAX'(w_next)));
      r_wrap     <= w_wrap;
      r_at_limit <= w_at_limit;
    end
  end

  assign bin_q    = r_bin;
  assign gray_q   = r_gray;
  assign wrap     = r_wrap;
  assign at_limit = r_at_limit;

  gray_decode_stage #(
    .WIDTH(WIDTH)
  ) u_decode (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (dec_valid_in),
    .i_gray  (gray_in),
    .o_valid (dec_valid_out),
    .o_bin   (dec_bin_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_gray_code_counter.sv
`default_nettype none
// Bench for gray_code_counter: wrapping and saturating instances driven in parallel,
// checked every cycle against an arithmetic model plus directed literal expectations.
module tb_gray_code_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         dec_valid_in = 1'b0;
  logic [W-1:0] gray_in = '0;

  logic [W-1:0] bin_q   [2];
  logic [W-1:0] gray_q  [2];
  logic         wrap    [2];
  logic         at_lim  [2];
  logic         dv_out  [2];
  logic [W-1:0] db_out  [2];

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(W), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_q(bin_q[0]), .gray_q(gray_q[0]), .wrap(wrap[0]), .at_limit(at_lim[0]),
    .dec_valid_in(dec_valid_in), .gray_in(gray_in),
    .dec_valid_out(dv_out[0]), .dec_bin_out(db_out[0])
  );

  gray_code_counter #(.WIDTH(W), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .bin_q(bin_q[1]), .gray_q(gray_q[1]), .wrap(wrap[1]), .at_limit(at_lim[1]),
    .dec_valid_in(dec_valid_in), .gray_in(gray_in),
    .dec_valid_out(dv_out[1]), .dec_bin_out(db_out[1])
  );

  // ---------------- reference model ----------------
  function automatic int gray_of(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int decode_of(int g);
    for (int b = 0; b <= MAXV; b++) if (gray_of(b) == g) return b;
    return -1;
  endfunction

  function automatic int model_next(int b, bit sat, bit ld, int lv, bit e, bit u);
    int t;
    if (ld) return lv;
    if (!e) return b;
    t = u ? b + 1 : b - 1;
    if (t < 0 || t > MAXV) return sat ? b : (t + MAXV + 1) % (MAXV + 1);
    return t;
  endfunction

  function automatic bit model_wrap(int b, bit sat, bit ld, bit e, bit u);
    return !ld && e && !sat && (u ? (b == MAXV) : (b == 0));
  endfunction

  int m_bin  [2];
  bit m_wrap [2];
  bit m_lim  [2];
  bit m_step [2];
  bit m_dv;
  int m_db;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_bin[k] <= 0; m_wrap[k] <= 1'b0; m_lim[k] <= 1'b0; m_step[k] <= 1'b0;
      end
      m_dv <= 1'b0;
      m_db <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_bin[k]  <= model_next(m_bin[k], k == 1, load, int'(load_val), en, up_dn);
        m_wrap[k] <= model_wrap(m_bin[k], k == 1, load, en, up_dn);
        m_lim[k]  <= up_dn ? (model_next(m_bin[k], k == 1, load, int'(load_val), en, up_dn) == MAXV)
                           : (model_next(m_bin[k], k == 1, load, int'(load_val), en, up_dn) == 0);
        m_step[k] <= !load && (model_next(m_bin[k], k == 1, 1'b0, 0, en, up_dn) != m_bin[k]);
      end
      m_dv <= dec_valid_in;
      if (dec_valid_in) m_db <= decode_of(int'(gray_in));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] prev_gray [2];
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("m%0d.bin_q", k),    int'(bin_q[k]),  m_bin[k]);
        chk($sformatf("m%0d.gray_q", k),   int'(gray_q[k]), gray_of(m_bin[k]));
        chk($sformatf("m%0d.wrap", k),     int'(wrap[k]),   int'(m_wrap[k]));
        chk($sformatf("m%0d.at_limit", k), int'(at_lim[k]), int'(m_lim[k]));
        chk($sformatf("m%0d.dec_valid", k), int'(dv_out[k]), int'(m_dv));
        chk($sformatf("m%0d.dec_bin", k),  int'(db_out[k]), m_db);
        if (m_step[k] && rst_n)
          chk($sformatf("m%0d.gray_1bit", k), $countones(gray_q[k] ^ prev_gray[k]), 1);
      end
    end
    prev_gray[0] = gray_q[0];
    prev_gray[1] = gray_q[1];
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int gseq [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int dec_g [3] = '{8, 13, 1};
  int dec_b [3] = '{15, 9, 1};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst.bin_q", int'(bin_q[k]), 0);
      chk("rst.gray_q", int'(gray_q[k]), 0);
      chk("rst.wrap", int'(wrap[k]), 0);
      chk("rst.at_limit", int'(at_lim[k]), 0);
      chk("rst.dec_valid", int'(dv_out[k]), 0);
      chk("rst.dec_bin", int'(db_out[k]), 0);
    end
    chk_on = 1'b1;
    rst_n = 1'b1;

    // Full up-count cycle with wrap on 15->0.
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("up.gray_seq", int'(gray_q[0]), gseq[i % 16]);
      chk("up.wrap", int'(wrap[0]), (i == 16) ? 1 : 0);
    end

    // Load beats enable.
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0;
    chk("load.bin_q", int'(bin_q[0]), 9);
    chk("load.gray_q", int'(gray_q[0]), 13);
    chk("load.wrap", int'(wrap[0]), 0);

    // Down from zero.
    en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b0;
    tick();
    chk("down.bin_q", int'(bin_q[0]), 15);
    chk("down.gray_q", int'(gray_q[0]), 8);
    chk("down.wrap", int'(wrap[0]), 1);
    chk("down.sat_bin", int'(bin_q[1]), 0);
    chk("down.sat_lim", int'(at_lim[1]), 1);
    en = 1'b0;
    tick();
    chk("down.wrap_end", int'(wrap[0]), 0);

    // Saturation at all-ones.
    load = 1'b1; load_val = 4'd14; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat.bin_q", int'(bin_q[1]), 15);
      chk("sat.gray_q", int'(gray_q[1]), 8);
      chk("sat.at_limit", int'(at_lim[1]), 1);
      chk("sat.wrap", int'(wrap[1]), 0);
    end
    en = 1'b0;

    // Back-to-back decodes.
    for (int i = 0; i < 3; i++) begin
      dec_valid_in = 1'b1; gray_in = W'(dec_g[i]);
      tick();
      chk("dec.valid", int'(dv_out[0]), 1);
      chk("dec.bin", int'(db_out[0]), dec_b[i]);
    end
    dec_valid_in = 1'b0; gray_in = 4'd6;
    tick();
    chk("dec.valid_drop", int'(dv_out[0]), 0);
    chk("dec.hold", int'(db_out[0]), 1);

    // Asynchronous reset between edges.
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0;
    chk("areset.pre", int'(bin_q[0]), 5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("areset.bin_q", int'(bin_q[k]), 0);
      chk("areset.gray_q", int'(gray_q[k]), 0);
      chk("areset.wrap", int'(wrap[k]), 0);
      chk("areset.at_limit", int'(at_lim[k]), 0);
      chk("areset.dec_valid", int'(dv_out[k]), 0);
      chk("areset.dec_bin", int'(db_out[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("areset.resume", int'(bin_q[0]), 1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      en           = 1'($urandom_range(0, 3) != 0);
      up_dn        = 1'($urandom_range(0, 1));
      load         = 1'($urandom_range(0, 9) == 0);
      load_val     = W'($urandom_range(0, MAXV));
      dec_valid_in = 1'($urandom_range(0, 1));
      gray_in      = W'($urandom_range(0, MAXV));
      rst_n        = 1'($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
Parametrised up/down counter that keeps a binary count and its Gray-code equivalent, both registered. Supports synchronous load, optional saturation instead of wrap-around, and a wrap pulse. Also contains an independent, pipelined Gray-to-binary decode path for Gray values arriving from other blocks, such as CDC pointers. It is the sequential, width-generic successor to the 4-bit binary-to-Gray converter and is used for FIFO pointers and position encoders.

Parameters:
WIDTH, 4, counter/decode data width in bits; legal range 2..32
SATURATE, 0, 0 = count wraps modulo 2^WIDTH; 1 = count holds at its limit

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  binary value to load
bin_q  output  WIDTH  registered binary count
gray_q  output  WIDTH  registered Gray code of bin_q
wrap  output  1  one-cycle pulse on wrap-around
at_limit  output  1  registered; high when bin_q is all-ones (up_dn=1) or zero (up_dn=0)
dec_valid_in  input  1  Gray decode request strobe
gray_in  input  WIDTH  Gray value to decode
dec_valid_out  output  1  decode result valid, 1 cycle after dec_valid_in
dec_bin_out  output  WIDTH  binary decode of gray_in

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-edge release): bin_q=0, gray_q=0, wrap=0, at_limit=0, dec_valid_out=0, dec_bin_out=0. Outputs clear immediately, with no clock edge, even mid-count.
- Per-edge priority: load > en > hold.
- load=1: bin_q<=load_val; gray_q<=bin2gray(load_val); wrap<=0. en and up_dn are ignored that cycle.
- en=1, up_dn=1: next = bin_q+1.
  - SATURATE=0: all-ones -> 0, with wrap<=1 for exactly one cycle.
  - SATURATE=1: all-ones holds; wrap stays 0.
- en=1, up_dn=0: next = bin_q-1.
  - SATURATE=0: 0 -> all-ones, with wrap<=1.
  - SATURATE=1: 0 holds.
- en=0, no load: bin_q and gray_q hold; wrap<=0.
- gray_q is registered from bin2gray(next binary), not derived combinationally from bin_q. gray_q is always bin2gray(bin_q) on the same cycle.
- Each count step changes exactly one bit of gray_q. Load may change several bits.
- Arithmetic is modulo 2^WIDTH, unsigned. bin2gray(b) = b ^ (b>>1).
- at_limit is registered from the next-state value and the current up_dn. It is 0 in reset.
- Decode path is fully independent of the counter.
  - Each edge: dec_valid_out<=dec_valid_in.
  - If dec_valid_in=1: dec_bin_out<=gray2bin(gray_in). Otherwise dec_bin_out holds.
  - gray2bin: bit[W-1]=g[W-1]; bit[i]=bit[i+1]^g[i].
  - Latency 1 cycle; throughput 1 per cycle; back-to-back requests allowed.
- Counter and decoder may operate in the same cycle without interaction.

Decomposition:
- Package gray_pkg:
  - functions bin2gray and gray2bin, width-generic via a WIDTH_MAX=32 argument slice
  - localparam WIDTH_MAX
- One sub-module: gray_decode_stage (WIDTH). Holds the registered Gray-to-binary path: dec_valid_in/gray_in to dec_valid_out/dec_bin_out. Instantiated once.
- Counter, saturation and wrap logic live in the top module.

Test Plan:
- Reset, then en=1, up_dn=1 for 16 cycles (WIDTH=4) -> gray_q = 0000,0001,0011,0010,0110,0111,0101,0100,1100,...,1000, then 0000. wrap=1 only on the 1111->0000 edge. Single-bit gray change every step.
- load=1, load_val=1001 with en=1 in the same cycle -> next cycle bin_q=1001, gray_q=1101 (load wins). wrap=0.
- From reset, en=1, up_dn=0 for 1 cycle -> bin_q=1111, gray_q=1000, wrap pulses for 1 cycle.
- SATURATE=1: load 1110, then en=1, up_dn=1 for 3 cycles -> bin_q 1111, 1111, 1111; gray_q=1000; at_limit=1; wrap never asserts.
- Decoder: dec_valid_in=1 with gray_in=1000, 1101, 0001 on consecutive cycles -> dec_bin_out=1111, 1001, 0001 one cycle later each, with dec_valid_out high 3 cycles. Counter unaffected.
- Assert rst_n=0 between clock edges while bin_q=0101 -> all outputs 0 immediately. After release, counting resumes from 0.
